mem_access_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, fed directly by the EX/MEM pipeline register. It performs loads and stores against a variable-latency data-memory port and stalls the front of the pipeline while an access is outstanding. It selects the write-back value (load data or ALU result) and registers it into the MEM/WB boundary. A watchdog bounds every access.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_wb_register.sv | 31 +++
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 tb/tb_mem_access_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W               = 32;
    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned DEFAULT_DMEM_TIMEOUT = 255;

    // Access FSM: IDLE issues requests, WAIT holds until ready or watchdog expiry.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Write-back data source select.
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    // Watchdog counter width; at least one bit even with the watchdog disabled.
    function automatic int unsigned wait_count_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears the write enable and holds address/data.
module mem_wb_register
    import mem_stage_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bubble,
    input  logic                  capture_write,
    input  logic [REG_ADDR_W-1:0] capture_address,
    input  logic [DATA_W-1:0]     capture_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0]     reg_data
);

    // Capture the next write-back slot, or insert a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write   <= 1'b0;
            reg_address <= '0;
            reg_data    <= '0;
        end else if (bubble) begin
            reg_write   <= 1'b0;
        end else begin
            reg_write   <= capture_write;
            reg_address <= capture_address;
            reg_data    <= capture_data;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: variable-latency data-memory port, stall generation,
// access watchdog and write-back select.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = DEFAULT_DMEM_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_shouldWriteRegister,
    input  logic [REG_ADDR_W-1:0] mem_registerWriteAddress,
    input  logic                  mem_shouldWriteMemoryElseAluOutputToRegister,
    input  logic [DATA_W-1:0]     mem_aluOutput,
    input  logic                  mem_shouldWriteMemory,
    input  logic [DATA_W-1:0]     mem_registerRtOrZero,
    output logic                  dmem_request,
    output logic                  dmem_write,
    output logic [DATA_W-1:0]     dmem_address,
    output logic [DATA_W-1:0]     dmem_writeData,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_readData,
    output logic                  memStall,
    output logic                  wb_shouldWriteRegister,
    output logic [REG_ADDR_W-1:0] wb_registerWriteAddress,
    output logic [DATA_W-1:0]     wb_registerWriteData,
    output logic                  busError,
    output logic                  misalignedAccess
);

    localparam int unsigned       CNT_W    = wait_count_width(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    mem_state_t       state;
    mem_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic        is_load;
    logic        is_store;
    logic        wants_access;
    logic        misaligned;
    logic        access;
    logic        timeout_hit;
    logic        completion;
    logic        timeout;
    logic        bubble;
    logic        wb_sel;
    logic [DATA_W-1:0] wb_data;

    assign is_load      = mem_shouldWriteMemoryElseAluOutputToRegister;
    assign is_store     = mem_shouldWriteMemory;
    // Gating by reset withdraws the request as soon as reset asserts.
    assign wants_access = (is_load | is_store) & ~reset;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = wants_access & (mem_aluOutput[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign access      = wants_access & ~misaligned;
    assign timeout_hit = (DMEM_TIMEOUT != 0) && (state == WAIT) && (count == CNT_LAST);
    assign completion  = access & dmem_ready;
    assign timeout     = access & ~dmem_ready & timeout_hit;
    // Any access not completing this cycle (stall, timeout, misaligned) is a bubble.
    assign bubble      = wants_access & ~completion;

    assign dmem_request   = access;
    assign dmem_write     = access & is_store;
    assign dmem_address   = mem_aluOutput;
    assign dmem_writeData = mem_registerRtOrZero;
    assign memStall       = access & ~dmem_ready & ~timeout_hit;

    // Load data only for a pure load; a load+store combination is treated as a store.
    assign wb_sel  = (completion & is_load & ~is_store) ? WB_SEL_MEM : WB_SEL_ALU;
    assign wb_data = (wb_sel == WB_SEL_MEM) ? dmem_readData : mem_aluOutput;

    // State and watchdog counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and watchdog counter logic.
    always_comb begin
        state_next = state;
        count_next = '0;
        case (state)
            IDLE: begin
                if (access && !dmem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                count_next = count + CNT_W'(1);
                if (dmem_ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sticky bus error on watchdog expiry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busError <= 1'b0;
        end else if (timeout) begin
            busError <= 1'b1;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle pulse for each rejected misaligned access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalignedAccess <= 1'b0;
        end else begin
            misalignedAccess <= misaligned;
        end
    end
`else
    assign misalignedAccess = 1'b0;
`endif

    mem_wb_register u_mem_wb_register (
        .clock           (clock),
        .reset           (reset),
        .bubble          (bubble),
        .capture_write   (mem_shouldWriteRegister),
        .capture_address (mem_registerWriteAddress),
        .capture_data    (wb_data),
        .reg_write       (wb_shouldWriteRegister),
        .reg_address     (wb_registerWriteAddress),
        .reg_data        (wb_registerWriteData)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_shouldWriteRegister;
    logic [4:0]  mem_registerWriteAddress;
    logic        mem_shouldWriteMemoryElseAluOutputToRegister;
    logic [31:0] mem_aluOutput;
    logic        mem_shouldWriteMemory;
    logic [31:0] mem_registerRtOrZero;
    logic        dmem_request;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_writeData;
    logic        dmem_ready;
    logic [31:0] dmem_readData;
    logic        memStall;
    logic        wb_shouldWriteRegister;
    logic [4:0]  wb_registerWriteAddress;
    logic [31:0] wb_registerWriteData;
    logic        busError;
    logic        misalignedAccess;

    mem_access_stage #(.DMEM_TIMEOUT(T)) dut (
        .clock                                        (clock),
        .reset                                        (reset),
        .mem_shouldWriteRegister                      (mem_shouldWriteRegister),
        .mem_registerWriteAddress                     (mem_registerWriteAddress),
        .mem_shouldWriteMemoryElseAluOutputToRegister (mem_shouldWriteMemoryElseAluOutputToRegister),
        .mem_aluOutput                                (mem_aluOutput),
        .mem_shouldWriteMemory                        (mem_shouldWriteMemory),
        .mem_registerRtOrZero                         (mem_registerRtOrZero),
        .dmem_request                                 (dmem_request),
        .dmem_write                                   (dmem_write),
        .dmem_address                                 (dmem_address),
        .dmem_writeData                               (dmem_writeData),
        .dmem_ready                                   (dmem_ready),
        .dmem_readData                                (dmem_readData),
        .memStall                                     (memStall),
        .wb_shouldWriteRegister                       (wb_shouldWriteRegister),
        .wb_registerWriteAddress                      (wb_registerWriteAddress),
        .wb_registerWriteData                         (wb_registerWriteData),
        .busError                                     (busError),
        .misalignedAccess                             (misalignedAccess)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic        st;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          nwait;     // cycles before ready; > T means never ready
        logic        idle_rdy;  // stray ready level for non-access instructions
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    // Reference model state: expected MEM/WB contents and sticky error.
    logic        exp_w;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic wreg,
                                input logic [4:0] waddr, input logic [31:0] alu,
                                input logic [31:0] rt, input logic [31:0] rdata,
                                input int nwait, input logic idle_rdy);
        vec_t v;
        v.ld = ld; v.st = st; v.wreg = wreg; v.waddr = waddr; v.alu = alu;
        v.rt = rt; v.rdata = rdata; v.nwait = nwait; v.idle_rdy = idle_rdy;
        return v;
    endfunction

    // Apply one instruction for as many cycles as it occupies; called just after a rising edge.
    task automatic run_instr(input vec_t v);
        logic acc, mis, real_acc, completes, last;
        int   ncyc;
        acc = v.ld | v.st;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (v.alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        real_acc  = acc & ~mis;
        completes = real_acc && (v.nwait <= T);
        ncyc      = real_acc ? (((v.nwait < T) ? v.nwait : T) + 1) : 1;
        for (int c = 0; c < ncyc; c++) begin
            mem_shouldWriteRegister                      = v.wreg;
            mem_registerWriteAddress                     = v.waddr;
            mem_shouldWriteMemoryElseAluOutputToRegister = v.ld;
            mem_shouldWriteMemory                        = v.st;
            mem_aluOutput                                = v.alu;
            mem_registerRtOrZero                         = v.rt;
            dmem_ready    = real_acc ? (c == v.nwait) : v.idle_rdy;
            dmem_readData = (real_acc && c == v.nwait) ? v.rdata : ~v.rdata;
            #1;
            last = (c == ncyc - 1);
            chk("memStall", 32'(memStall), 32'(real_acc && !last));
            chk("dmem_request", 32'(dmem_request), 32'(real_acc));
            if (real_acc) begin
                chk("dmem_write", 32'(dmem_write), 32'(v.st));
                chk("dmem_address", dmem_address, v.alu);
                chk("dmem_writeData", dmem_writeData, v.rt);
            end
            @(posedge clock);
            #1;
            if (!last || mis) begin
                exp_w = 1'b0;
            end else if (!acc) begin
                exp_w = v.wreg; exp_a = v.waddr; exp_d = v.alu;
            end else if (completes) begin
                exp_w = v.wreg; exp_a = v.waddr;
                exp_d = (v.ld && !v.st) ? v.rdata : v.alu;
            end else begin
                exp_w = 1'b0; exp_be = 1'b1;
            end
            chk("wb_write", 32'(wb_shouldWriteRegister), 32'(exp_w));
            chk("wb_addr", 32'(wb_registerWriteAddress), 32'(exp_a));
            chk("wb_data", wb_registerWriteData, exp_d);
            chk("busError", 32'(busError), 32'(exp_be));
            chk("misalignedAccess", 32'(misalignedAccess), 32'(mis && last));
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int k;
        k = $urandom_range(0, 3);
        v.ld = (k == 1) || (k == 3);
        v.st = (k == 2) || (k == 3);
        v.wreg = 1'($urandom_range(0, 1));
        v.waddr = 5'($urandom);
        v.alu = $urandom;
        if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
        v.rt = $urandom;
        v.rdata = $urandom;
        v.nwait = ($urandom_range(0, 7) == 0) ? (T + 1 + int'($urandom_range(0, 2)))
                                               : int'($urandom_range(0, T));
        v.idle_rdy = 1'($urandom_range(0, 1));
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(0, 0, 1, 5'd5,  32'h0000_1234, 32'h0,      32'h0,         0, 0); // ALU op
        tbl[1] = mk(1, 0, 1, 5'd8,  32'h0000_0100, 32'h0,      32'hDEAD_BEEF, 3, 0); // 3-wait load
        tbl[2] = mk(0, 1, 0, 5'd2,  32'h0000_0200, 32'hCAFE,   32'h0,         0, 0); // zero-wait store
        tbl[3] = mk(0, 0, 1, 5'd6,  32'h0000_0777, 32'h0,      32'h0,         0, 1); // stray ready ignored
        tbl[4] = mk(1, 1, 1, 5'd3,  32'h0000_0208, 32'h1111,   32'h5555_AAAA, 1, 0); // load+store = store
        tbl[5] = mk(1, 0, 1, 5'd10, 32'h0000_0300, 32'h0,      32'h0BAD_F00D, T, 0); // ready on last cycle
        tbl[6] = mk(1, 0, 1, 5'd4,  32'h0000_0102, 32'h0,      32'h0000_0055, 0, 1); // misaligned load
        tbl[7] = mk(0, 1, 1, 5'd7,  32'h0000_0400, 32'h2222,   32'h0,         2, 0); // store keeps reg write
        tbl[8] = mk(1, 0, 1, 5'd9,  32'h0000_0104, 32'h0,      32'h1234_5678, 7, 0); // watchdog timeout
        tbl[9] = mk(1, 0, 1, 5'd11, 32'h0000_0108, 32'h0,      32'hFEED_FACE, 0, 0); // back-to-back after timeout

        // Reset values, with a load presented to confirm the request is gated.
        reset = 1'b1;
        mem_shouldWriteRegister = 1'b1;
        mem_registerWriteAddress = 5'd1;
        mem_shouldWriteMemoryElseAluOutputToRegister = 1'b1;
        mem_shouldWriteMemory = 1'b0;
        mem_aluOutput = 32'h40;
        mem_registerRtOrZero = 32'h0;
        dmem_ready = 1'b0;
        dmem_readData = 32'h0;
        exp_w = 1'b0; exp_a = 5'd0; exp_d = 32'h0; exp_be = 1'b0;
        #3;
        chk("reset dmem_request", 32'(dmem_request), 32'h0);
        chk("reset memStall", 32'(memStall), 32'h0);
        chk("reset wb_write", 32'(wb_shouldWriteRegister), 32'h0);
        chk("reset wb_addr", 32'(wb_registerWriteAddress), 32'h0);
        chk("reset wb_data", wb_registerWriteData, 32'h0);
        chk("reset busError", 32'(busError), 32'h0);
        chk("reset misalignedAccess", 32'(misalignedAccess), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_instr(tbl[i]);

        // Reset during WAIT of a load: request withdrawn and WB cleared immediately.
        mem_shouldWriteRegister = 1'b1;
        mem_registerWriteAddress = 5'd12;
        mem_shouldWriteMemoryElseAluOutputToRegister = 1'b1;
        mem_shouldWriteMemory = 1'b0;
        mem_aluOutput = 32'h500;
        dmem_ready = 1'b0;
        dmem_readData = 32'h9999_9999;
        #1;
        chk("midwait stall c0", 32'(memStall), 32'h1);
        @(posedge clock);
        #1;
        chk("midwait stall c1", 32'(memStall), 32'h1);
        chk("midwait request c1", 32'(dmem_request), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("midwait reset dmem_request", 32'(dmem_request), 32'h0);
        chk("midwait reset memStall", 32'(memStall), 32'h0);
        chk("midwait reset wb_write", 32'(wb_shouldWriteRegister), 32'h0);
        chk("midwait reset wb_addr", 32'(wb_registerWriteAddress), 32'h0);
        chk("midwait reset wb_data", wb_registerWriteData, 32'h0);
        chk("midwait reset busError", 32'(busError), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_w = 1'b0; exp_a = 5'd0; exp_d = 32'h0; exp_be = 1'b0;
        chk("state after reset", 32'(dut.state), 32'(IDLE));
        // A fresh timeout must take the full T stall cycles (counter restarted).
        run_instr(mk(1, 0, 1, 5'd13, 32'h0000_0600, 32'h0, 32'h0, T + 2, 0));
        run_instr(mk(1, 0, 1, 5'd14, 32'h0000_0604, 32'h0, 32'hA5A5_5A5A, 1, 0));

        // Randomized instruction stream against the model.
        for (int i = 0; i < 200; i++) run_instr(rand_vec());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
